// File: rtl/arp_responder.sv
// ARP responder: watches the de-framed receive byte stream for ARP requests
// aimed at this station and streams a 60-byte ARP reply to the MAC transmit side.
module arp_responder #(
  parameter logic [47:0] MAC_ADDR = 48'h00_0A_35_00_00_01,
  parameter logic [31:0] IP_ADDR  = 32'hC0_A8_01_0A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic        rx_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] reply_count
);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop, StSend} state_e;

  // Ethertype + fixed ARP header (htype, ptype, hlen, plen, oper)
  localparam logic [79:0] ReqHdr = 80'h0806_0001_0800_0604_0001;
  localparam logic [79:0] RepHdr = 80'h0806_0001_0800_0604_0002;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        rx_mid_q, rx_mid_d;
  logic        dst_bc_q, dst_bc_d;
  logic        dst_uc_q, dst_uc_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_last_q, tx_last_d;
  logic [15:0] count_q, count_d;

  logic [5:0]  cur_idx;
  logic        bc_now, uc_now, byte_ok;

  // Byte k (0 = most significant) of an n-byte big-endian field.
  function automatic logic [7:0] pick(input logic [79:0] v, input int unsigned n,
                                      input int unsigned k);
    return 8'(v >> (8 * (n - 1 - k)));
  endfunction

  // Fixed-value checks for header and target IP bytes; other bytes always pass.
  function automatic logic hdr_ok(input logic [5:0] i, input logic [7:0] d);
    int unsigned k;
    k = 32'(i);
    if (k >= 12 && k <= 21) return d == pick(ReqHdr, 10, k - 12);
    if (k >= 38 && k <= 41) return d == pick(80'(IP_ADDR), 4, k - 38);
    return 1'b1;
  endfunction

  function automatic logic [7:0] reply_byte(input logic [5:0] i, input logic [47:0] sha,
                                            input logic [31:0] spa);
    int unsigned k;
    k = 32'(i);
    if (k < 6)  return pick(80'(sha), 6, k);
    if (k < 12) return pick(80'(MAC_ADDR), 6, k - 6);
    if (k < 22) return pick(RepHdr, 10, k - 12);
    if (k < 28) return pick(80'(MAC_ADDR), 6, k - 22);
    if (k < 32) return pick(80'(IP_ADDR), 4, k - 28);
    if (k < 38) return pick(80'(sha), 6, k - 32);
    if (k < 42) return pick(80'(spa), 4, k - 38);
    return 8'h00;
  endfunction

  // Per-byte receive check; destination must be wholly broadcast or wholly ours.
  always_comb begin
    cur_idx = (state_q == StRecv) ? idx_q : 6'd0;
    bc_now  = ((cur_idx == 6'd0) || dst_bc_q) && (rx_data == 8'hFF);
    uc_now  = ((cur_idx == 6'd0) || dst_uc_q) &&
              (rx_data == pick(80'(MAC_ADDR), 6, 32'(cur_idx)));
    byte_ok = (cur_idx < 6'd6) ? (bc_now || uc_now) : hdr_ok(cur_idx, rx_data);
  end

  // Next-state logic for the frame FSM, capture registers and reply stream.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rx_mid_d  = rx_mid_q;
    dst_bc_d  = dst_bc_q;
    dst_uc_d  = dst_uc_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    tx_data_d = tx_data_q;
    tx_last_d = tx_last_q;
    count_d   = count_q;

    if (rx_valid) rx_mid_d = !rx_last;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_mid_q) begin
            // Joined a frame part-way through; a lone tail beat needs no drop.
            if (!rx_last) state_d = StDrop;
          end else begin
            idx_d    = 6'd1;
            dst_bc_d = bc_now;
            dst_uc_d = uc_now;
            if (!rx_last) state_d = byte_ok ? StRecv : StDrop;
          end
        end
      end
      StRecv: begin
        if (rx_valid) begin
          idx_d = (idx_q == 6'd63) ? idx_q : idx_q + 6'd1;
          if (cur_idx < 6'd6) begin
            dst_bc_d = bc_now;
            dst_uc_d = uc_now;
          end
          if (cur_idx >= 6'd22 && cur_idx <= 6'd27) sha_d = {sha_q[39:0], rx_data};
          if (cur_idx >= 6'd28 && cur_idx <= 6'd31) spa_d = {spa_q[23:0], rx_data};
          if (!byte_ok) begin
            state_d = rx_last ? StIdle : StDrop;
          end else if (rx_last) begin
            if (cur_idx >= 6'd41 && !rx_error) begin
              state_d   = StSend;
              idx_d     = 6'd0;
              tx_data_d = reply_byte(6'd0, sha_q, spa_q);
              tx_last_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StDrop: begin
        if (rx_valid && rx_last) state_d = StIdle;
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == 6'd59) begin
            state_d   = StIdle;
            idx_d     = 6'd0;
            count_d   = count_q + 16'd1;
            tx_data_d = 8'h00;
            tx_last_d = 1'b0;
          end else begin
            idx_d     = idx_q + 6'd1;
            tx_data_d = reply_byte(idx_q + 6'd1, sha_q, spa_q);
            tx_last_d = (idx_q == 6'd58);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 6'd0;
      rx_mid_q  <= 1'b0;
      dst_bc_q  <= 1'b0;
      dst_uc_q  <= 1'b0;
      sha_q     <= 48'd0;
      spa_q     <= 32'd0;
      tx_data_q <= 8'h00;
      tx_last_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rx_mid_q  <= rx_mid_d;
      dst_bc_q  <= dst_bc_d;
      dst_uc_q  <= dst_uc_d;
      sha_q     <= sha_d;
      spa_q     <= spa_d;
      tx_data_q <= tx_data_d;
      tx_last_q <= tx_last_d;
      count_q   <= count_d;
    end
  end

  // tx_valid/busy decode straight from state so reset clears them at once.
  always_comb begin
    tx_valid    = (state_q == StSend);
    busy        = (state_q == StSend);
    tx_data     = tx_data_q;
    tx_last     = tx_last_q;
    reply_count = count_q;
  end

endmodule

// File: tb/tb_arp_responder.sv
// Self-checking bench for arp_responder: directed and randomized ARP frames
// checked against a field-level reference of the expected reply.
module tb_arp_responder;

  localparam logic [47:0] MAC   = 48'h00_0A_35_00_00_01;
  localparam logic [31:0] IP    = 32'hC0_A8_01_0A;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_last, rx_error;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, tx_ready, busy;
  logic [15:0] reply_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit rand_ready = 1'b0;

  logic [8:0]  txq[$];
  logic [7:0]  frm[$];
  logic [8:0]  rep[$];

  logic        hold = 1'b0;
  logic [8:0]  held = '0;
  logic        in_frame = 1'b0;

  arp_responder dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_last    (rx_last),
    .rx_error   (rx_error),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .reply_count(reply_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit monitor: records transfers, checks stall stability and no gaps.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        hold     = 1'b0;
        in_frame = 1'b0;
      end else begin
        if (hold) begin
          chk("stall_valid", 64'(tx_valid), 64'd1);
          chk("stall_data", 64'({tx_last, tx_data}), 64'(held));
        end else if (in_frame) begin
          chk("valid_gap", 64'(tx_valid), 64'd1);
        end
        hold = tx_valid && !tx_ready;
        held = {tx_last, tx_data};
        if (tx_valid && tx_ready) begin
          txq.push_back({tx_last, tx_data});
          in_frame = !tx_last;
        end
      end
    end
  end

  // tx_ready driver: always-ready or 50% random.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_field(input logic [79:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build_req(input logic [47:0] dst, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [31:0] tpa,
                           input logic [15:0] etype);
    frm.delete();
    push_field(80'(dst), 6);
    push_field(80'(sha), 6);
    push_field(80'(etype), 2);
    push_field(80'h0001_0800_0604_0001, 8);
    push_field(80'(sha), 6);
    push_field(80'(spa), 4);
    push_field(80'd0, 6);
    push_field(80'(tpa), 4);
    for (int i = 0; i < 18; i++) frm.push_back(8'h00);
  endtask

  task automatic rep_field(input logic [79:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) rep.push_back({1'b0, v[8*i +: 8]});
  endtask

  task automatic build_rep(input logic [47:0] sha, input logic [31:0] spa);
    rep.delete();
    rep_field(80'(sha), 6);
    rep_field(80'(MAC), 6);
    rep_field(80'h0806, 2);
    rep_field(80'h0001_0800_0604_0002, 8);
    rep_field(80'(MAC), 6);
    rep_field(80'(IP), 4);
    rep_field(80'(sha), 6);
    rep_field(80'(spa), 4);
    for (int i = 0; i < 18; i++) rep.push_back(9'h000);
    rep[59][8] = 1'b1;
  endtask

  // Drives frm[0..len-1]; enters and leaves 1 ns after a rising edge.
  task automatic send_frame(input int len, input bit err);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_data  = frm[i];
      rx_last  = (i == len - 1);
      rx_error = err && (i == len - 1);
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (txq.size() < n && t < 600) begin
      @(posedge clock);
      #1;
      t++;
    end
  endtask

  task automatic compare_rep(input string tag);
    logic [8:0] o;
    chk({tag, "_nbytes"}, 64'(txq.size()), 64'd60);
    for (int i = 0; i < 60; i++) begin
      o = (i < txq.size()) ? txq[i] : 9'bx;
      chk($sformatf("%s_b%0d", tag, i), 64'(o), 64'(rep[i]));
    end
    txq.delete();
  endtask

  task automatic run_case(input string tag, input logic [47:0] dst, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa,
                          input logic [15:0] etype, input int len, input bit err);
    bit accept;
    accept = (dst == BCAST || dst == MAC) && etype == 16'h0806 && tpa == IP &&
             len >= 42 && !err;
    build_req(dst, sha, spa, tpa, etype);
    send_frame(len, err);
    chk({tag, "_lat_valid"}, 64'(tx_valid), 64'(accept));
    chk({tag, "_lat_busy"}, 64'(busy), 64'(accept));
    if (accept) begin
      build_rep(sha, spa);
      wait_tx(60);
      exp_count++;
      compare_rep(tag);
      chk({tag, "_valid_after"}, 64'(tx_valid), 64'd0);
    end else begin
      repeat (70) @(posedge clock);
      #1;
      chk({tag, "_no_reply"}, 64'(txq.size()), 64'd0);
      txq.delete();
    end
    chk({tag, "_count"}, 64'(reply_count), 64'(exp_count));
  endtask

  initial begin
    logic [47:0] sha, dst;
    logic [31:0] spa, tpa;
    logic [15:0] et;
    bit          err;
    int          kind, t;

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_last", 64'(tx_last), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(reply_count), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed cases
    run_case("bcast", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP, 16'h0806, 60, 1'b0);
    run_case("bad_tpa", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, 32'hC0A8010B,
             16'h0806, 60, 1'b0);
    run_case("other_dst", 48'h02_11_22_33_44_55, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP,
             16'h0806, 60, 1'b0);
    run_case("ipv4_type", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP, 16'h0800, 60, 1'b0);
    run_case("rx_err", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP, 16'h0806, 60, 1'b1);
    run_case("short", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP, 16'h0806, 31, 1'b0);
    run_case("unicast", MAC, 48'h02_00_00_00_00_BB, 32'hC0A80106, IP, 16'h0806, 60, 1'b0);
    run_case("min_len", BCAST, 48'h02_00_00_00_00_CC, 32'hC0A80107, IP, 16'h0806, 42, 1'b0);

    // Stalled reply must produce the identical byte sequence
    rand_ready = 1'b1;
    run_case("stall", BCAST, 48'h02_00_00_00_00_AA, 32'hC0A80105, IP, 16'h0806, 60, 1'b0);
    rand_ready = 1'b0;

    // Second request starts during the reply and runs past its end
    build_req(BCAST, 48'h02_00_00_00_00_01, 32'hC0A80111, IP, 16'h0806);
    send_frame(60, 1'b0);
    chk("ovl_lat", 64'(tx_valid), 64'd1);
    repeat (10) @(posedge clock);
    #1;
    build_req(BCAST, 48'h02_00_00_00_00_02, 32'hC0A80112, IP, 16'h0806);
    for (int i = 0; i < 20; i++) frm.push_back(8'h00);
    send_frame(80, 1'b0);
    build_rep(48'h02_00_00_00_00_01, 32'hC0A80111);
    wait_tx(60);
    exp_count++;
    compare_rep("ovl_first");
    repeat (5) @(posedge clock);
    #1;
    chk("ovl_second_dropped", 64'(txq.size()), 64'd0);
    chk("ovl_count", 64'(reply_count), 64'(exp_count));
    run_case("ovl_third", BCAST, 48'h02_00_00_00_00_03, 32'hC0A80113, IP, 16'h0806, 60, 1'b0);

    // Randomized requests and corruptions
    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 5);
      rand_ready = 1'($urandom_range(0, 1));
      sha = {16'($urandom) & 16'hFEFF, 32'($urandom)};
      spa = 32'($urandom);
      dst = (kind == 1) ? MAC : (kind == 2) ? 48'h02_11_22_33_44_55 : BCAST;
      tpa = (kind == 3) ? IP + 32'd1 : IP;
      et  = (kind == 4) ? 16'h0800 : 16'h0806;
      err = (kind == 5);
      run_case($sformatf("rnd%0d_k%0d", n, kind), dst, sha, spa, tpa, et, 60, err);
    end
    rand_ready = 1'b0;

    // Reset in the middle of a reply
    build_req(BCAST, 48'h02_00_00_00_00_DD, 32'hC0A80120, IP, 16'h0806);
    send_frame(60, 1'b0);
    t = 0;
    while (txq.size() < 20 && t < 300) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("rstmid_progress", 64'(txq.size()), 64'd20);
    reset = 1'b1;
    #1;
    chk("rstmid_valid", 64'(tx_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_count", 64'(reply_count), 64'd0);
    exp_count = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    txq.delete();
    @(posedge clock);
    #1;
    run_case("post_rst", BCAST, 48'h02_00_00_00_00_EE, 32'hC0A80121, IP, 16'h0806, 60, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
